// File: rtl/ppu_pkg.sv
// Shared PPU sprite types: OAM entry layout, buffered slot record,
// sequencer state encoding and the scanline distance helper.
package ppu_pkg;

    localparam int SPRITE_H   = 16;
    localparam int GFX_ADDR_W = 12;

    // Field order is MSB first, matching the 32-bit OAM word
    typedef struct packed {
        logic       enable;
        logic [7:0] tile;
        logic [2:0] palette;
        logic       hflip;
        logic [8:0] y;
        logic [9:0] x;
    } oam_entry_t;

    typedef struct packed {
        logic [7:0] tile;
        logic [3:0] row;
        logic [9:0] x;
        logic [2:0] palette;
        logic       hflip;
    } slot_info_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_SCAN  = 3'd2,
        ST_FETCH = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // 9-bit subtraction wraps, so sprites straddling line 511/0 still hit
    function automatic logic [8:0] line_diff(input logic [8:0] line, input logic [8:0] y);
        return line - y;
    endfunction

endpackage

// File: rtl/sprite_eval_ctrl_if.sv
// Memory-side and shift-register-side bus of the sprite evaluator.
// master = evaluator, slave = OAM / sprite graphics / slot block side.
interface sprite_eval_ctrl_if #(
    parameter int NUM_OAM     = 64,
    parameter int MAX_SPRITES = 8
);
    logic [$clog2(NUM_OAM)-1:0]     oam_addr;
    logic [31:0]                    oam_data;
    logic [ppu_pkg::GFX_ADDR_W-1:0] gfx_addr;
    logic [63:0]                    gfx_data;
    logic [MAX_SPRITES-1:0]         slot_load;
    logic [63:0]                    slot_pattern;
    logic [9:0]                     slot_x;
    logic [2:0]                     slot_palette;

    modport master (
        output oam_addr, gfx_addr, slot_load, slot_pattern, slot_x, slot_palette,
        input  oam_data, gfx_data
    );

    modport slave (
        input  oam_addr, gfx_addr, slot_load, slot_pattern, slot_x, slot_palette,
        output oam_data, gfx_data
    );
endinterface

// File: rtl/sprite_row_flip.sv
// Horizontal mirror of a 16-pixel, 4bpp sprite row (nibble order reversal).
module sprite_row_flip (
    input  logic        hflip,
    input  logic [63:0] row_in,
    output logic [63:0] row_out
);
    logic [63:0] reversed;

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_nibble
            assign reversed[4*gi +: 4] = row_in[4*(15-gi) +: 4];
        end
    endgenerate

    assign row_out = hflip ? reversed : row_in;
endmodule

// File: rtl/sprite_eval_ctrl.sv
// Per-scanline sprite evaluation and pattern fetch sequencer.
// Define SPR_OVERFLOW_EN to always scan all of OAM and flag lines with too many sprites.
module sprite_eval_ctrl
    import ppu_pkg::*;
#(
    parameter int NUM_OAM     = 64,
    parameter int MAX_SPRITES = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         line_start,
    input  logic [8:0]                   next_line,
    sprite_eval_ctrl_if.master           bus,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(MAX_SPRITES):0] sprite_count,
    output logic                         overflow,
    output logic                         overrun
);
    localparam int AW = $clog2(NUM_OAM);
    localparam int CW = $clog2(MAX_SPRITES);
    localparam logic [AW:0] LAST_SCAN = (AW+1)'(NUM_OAM);
    localparam logic [CW:0] MAX_CNT   = (CW+1)'(MAX_SPRITES);

    state_t            state_reg, state_next;
    logic [8:0]        line_reg, line_next;
    logic [AW:0]       scan_reg, scan_next;
    logic [CW:0]       count_reg, count_next;
    logic [CW-1:0]     fetch_idx_reg, fetch_idx_next;
    logic              phase_reg, phase_next;
    logic              overrun_reg, overrun_next;

    oam_entry_t        entry;
    logic [8:0]        diff;
    logic              eval_hit;
    logic              buf_we;
    slot_info_t        buf_din;
    slot_info_t        slot_arr [MAX_SPRITES];
    slot_info_t        cur;
    logic [63:0]       flipped;

    logic [AW-1:0]         oam_addr;
    logic [GFX_ADDR_W-1:0] gfx_addr;
    logic [MAX_SPRITES-1:0] slot_load;
    logic [63:0]           slot_pattern;
    logic [9:0]            slot_x;
    logic [2:0]            slot_palette;

    // Entry for scan_reg-1 arrives while scan_reg is on the address bus
    assign entry    = oam_entry_t'(bus.oam_data);
    assign diff     = line_diff(line_reg, entry.y);
    assign eval_hit = (state_reg == ST_SCAN) && (scan_reg != '0) && entry.enable
                      && (diff < 9'(SPRITE_H));
    assign buf_din  = '{tile: entry.tile, row: diff[3:0], x: entry.x,
                        palette: entry.palette, hflip: entry.hflip};
    assign cur      = slot_arr[fetch_idx_reg];

    generate
        for (genvar gi = 0; gi < MAX_SPRITES; gi++) begin : g_slot
            slot_info_t entry_reg;
            always_ff @(posedge clk or posedge reset) begin
                if (reset)
                    entry_reg <= '0;
                else if (buf_we && count_reg[CW-1:0] == CW'(gi))
                    entry_reg <= buf_din;
            end
            assign slot_arr[gi] = entry_reg;
        end
    endgenerate

    sprite_row_flip u_flip (
        .hflip   (cur.hflip),
        .row_in  (bus.gfx_data),
        .row_out (flipped)
    );

`ifdef SPR_OVERFLOW_EN
    localparam bit STOP_WHEN_FULL = 1'b0;
    logic overflow_reg, overflow_next;

    always_comb begin
        overflow_next = overflow_reg;
        if (state_reg == ST_CLEAR)
            overflow_next = 1'b0;
        else if (eval_hit && count_reg == MAX_CNT)
            overflow_next = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) overflow_reg <= 1'b0;
        else       overflow_reg <= overflow_next;
    end

    assign overflow = overflow_reg;
`else
    localparam bit STOP_WHEN_FULL = 1'b1;
    assign overflow = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            line_reg      <= '0;
            scan_reg      <= '0;
            count_reg     <= '0;
            fetch_idx_reg <= '0;
            phase_reg     <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            line_reg      <= line_next;
            scan_reg      <= scan_next;
            count_reg     <= count_next;
            fetch_idx_reg <= fetch_idx_next;
            phase_reg     <= phase_next;
            overrun_reg   <= overrun_next;
        end
    end

    assign busy = (state_reg == ST_CLEAR) || (state_reg == ST_SCAN) || (state_reg == ST_FETCH);

    always_comb begin
        state_next     = state_reg;
        line_next      = line_reg;
        scan_next      = scan_reg;
        count_next     = count_reg;
        fetch_idx_next = fetch_idx_reg;
        phase_next     = phase_reg;
        overrun_next   = overrun_reg;
        buf_we         = 1'b0;
        oam_addr       = '0;
        gfx_addr       = '0;
        slot_load      = '0;
        slot_pattern   = '0;
        slot_x         = '0;
        slot_palette   = '0;

        case (state_reg)
            ST_IDLE: ;
            ST_CLEAR: begin
                count_next     = '0;
                scan_next      = '0;
                fetch_idx_next = '0;
                phase_next     = 1'b0;
                state_next     = ST_SCAN;
            end
            ST_SCAN: begin
                oam_addr  = scan_reg[AW-1:0];
                scan_next = scan_reg + 1'b1;
                if (eval_hit && count_reg != MAX_CNT) begin
                    buf_we     = 1'b1;
                    count_next = count_reg + 1'b1;
                end
                if (scan_reg == LAST_SCAN)
                    state_next = (count_next == '0) ? ST_DONE : ST_FETCH;
                else if (STOP_WHEN_FULL && count_next == MAX_CNT)
                    state_next = ST_FETCH;
            end
            ST_FETCH: begin
                // Phase 0 addresses the row, phase 1 hands the returned data to the slot
                if (!phase_reg) begin
                    gfx_addr   = {cur.tile, cur.row};
                    phase_next = 1'b1;
                end else begin
                    slot_load[fetch_idx_reg] = 1'b1;
                    slot_pattern   = flipped;
                    slot_x         = cur.x;
                    slot_palette   = cur.palette;
                    phase_next     = 1'b0;
                    fetch_idx_next = fetch_idx_reg + 1'b1;
                    if ({1'b0, fetch_idx_reg} + 1'b1 == count_reg)
                        state_next = ST_DONE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase

        if (line_start) begin
            line_next  = next_line;
            state_next = ST_CLEAR;
            if (busy)
                overrun_next = 1'b1;
        end
    end

    assign done         = (state_reg == ST_DONE);
    assign sprite_count = count_reg;
    assign overrun      = overrun_reg;

    assign bus.oam_addr     = oam_addr;
    assign bus.gfx_addr     = gfx_addr;
    assign bus.slot_load    = slot_load;
    assign bus.slot_pattern = slot_pattern;
    assign bus.slot_x       = slot_x;
    assign bus.slot_palette = slot_palette;
endmodule

// File: doc/sprite_eval_ctrl.md
Name: sprite_eval_ctrl

Overview:
Per-scanline sprite evaluation and fetch sequencer for the PPU. On each line-start pulse it scans OAM, selects up to MAX_SPRITES sprites that intersect the next scanline, fetches each selected sprite's pattern row from sprite graphics memory, and loads the sprite shift-register slots. It sits between the OAM/sprite_graphics read ports and the shift_register_block, and is timed by the VGA controller's line-start strobe.

Parameters:
NUM_OAM, 64, number of OAM entries scanned (power of 2)
MAX_SPRITES, 8, sprite slots per line (power of 2, <= NUM_OAM)
SPRITE_H, 16, sprite height in rows (fixed 16; row field is 4 bits)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
line_start  in  1  one-cycle pulse: begin evaluation for next_line
next_line  in  9  scanline (0..479) being prepared
oam_addr  out  log2(NUM_OAM)  OAM read address
oam_data  in  32  OAM entry, valid 1 cycle after oam_addr
gfx_addr  out  12  sprite graphics row address = {tile[7:0], row[3:0]}
gfx_data  in  64  16 pixels x 4bpp, pixel 0 in [3:0], valid 1 cycle after gfx_addr
slot_load  out  MAX_SPRITES  one-hot load strobe to shift-register slot
slot_pattern  out  64  pixel row (h-flip already applied)
slot_x  out  10  sprite x position
slot_palette  out  3  palette index
busy  out  1  evaluation/fetch in progress
done  out  1  one-cycle pulse when all loads complete
sprite_count  out  log2(MAX_SPRITES)+1  sprites loaded this line
overflow  out  1  more than MAX_SPRITES sprites on line (see feature)
overrun  out  1  sticky: line_start arrived while busy

Behaviour:
- OAM entry: [9:0] x, [18:10] y, [19] hflip, [22:20] palette, [30:23] tile, [31] enable.
- Hit: enable=1 and diff=(next_line - y) mod 512 < SPRITE_H; row=diff[3:0].
- Reset: state IDLE; all outputs 0, overrun cleared, slot buffer cleared.
- FSM IDLE -> CLEAR -> SCAN -> FETCH -> DONE -> IDLE.
- IDLE: line_start latches next_line, goes to CLEAR; busy=1 from next cycle.
- CLEAR (1 cycle): count=0, overflow=0, slot_load all zero.
- SCAN: oam_addr increments 0..NUM_OAM-1 one per cycle; entry i evaluated when it arrives one cycle later; hits appended in ascending OAM order (lower index = higher priority = lower slot) into internal buffer {tile,row,x,palette,hflip}. SCAN ends after entry NUM_OAM-1 evaluated (NUM_OAM+1 cycles), or early per feature.
- FETCH: per buffered slot k (k=0..count-1): cycle A drive gfx_addr; cycle B present slot_pattern/x/palette with slot_load[k]=1 for exactly one cycle. 2 cycles/slot; count=0 skips FETCH.
- hflip=1: slot_pattern pixel j = gfx_data pixel 15-j (4-bit nibble reversal).
- DONE: done=1 for one cycle, sprite_count valid and held until next CLEAR; return to IDLE.
- Slots not loaded on a line receive no strobe; downstream treats them as transparent via sprite_count.
- line_start while busy: abort current line, set overrun (sticky until reset), restart at CLEAR with new next_line; no done pulse for the aborted line.
- line_start in the DONE cycle is accepted normally (not an overrun).
- y wrap: y near 511 with next_line small hits through mod-512 arithmetic.
- Worst-case latency line_start->done: 1+(NUM_OAM+1)+2*MAX_SPRITES+1 = 83 cycles at defaults.

Optional Feature:
SPR_OVERFLOW_EN. Defined: SCAN always covers all NUM_OAM entries; a hit found when count==MAX_SPRITES sets overflow=1 (held until next CLEAR), extra sprite discarded. Undefined: SCAN terminates on the cycle the MAX_SPRITES-th hit is recorded (in-flight read dropped); overflow tied 0.

Decomposition:
- Package ppu_pkg: oam_entry_t packed struct (layout above), slot_info_t, SPRITE_H, GFX_ADDR_W, fsm state enum.
- Sub-module sprite_row_flip: combinational 16-nibble reversal selected by hflip.

Test Plan:
- OAM all disabled, line_start next_line=100 -> no slot_load, done after 67 cycles, sprite_count=0.
- Entry 5 y=95 tile=0x12 x=300 pal=3, line 100 -> gfx_addr=0x125, slot_load[0]=1 with x=300, palette=3, pattern=gfx_data.
- Same with hflip=1, gfx_data=0xFEDCBA9876543210 -> slot_pattern=0x0123456789ABCDEF.
- 10 sprites y=50, line 50 -> slots 0..7 = OAM 0..7, sprite_count=8; overflow=1 only with SPR_OVERFLOW_EN, and without it done arrives 2 cycles after OAM entry 7 evaluated plus 16 fetch cycles.
- Entry y=505, line 3 (diff=10) -> hit, row=10; y=200, line 216 (diff=16) -> no hit.
- Second line_start 20 cycles into scan -> overrun=1, no done for first line, done for second; assert reset mid-FETCH -> all outputs 0 immediately, overrun cleared.
